twofish_xtime: RTL and testbench



---
 rtl/twofish_xtime.sv | 63 ++++++
 tb/tb_twofish_xtime.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/twofish_xtime.sv
// Twofish MDS GF(2^8) constant multiplier: combinational xtime of x and a
// one-stage registered set of x*01, x*5B, x*EF products with a valid flag.
module twofish_xtime #(
    parameter logic [7:0] POLY = 8'h69
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] x,
    input  logic       in_valid,
    output logic [7:0] y,
    output logic       out_valid,
    output logic [7:0] m01,
    output logic [7:0] m5b,
    output logic [7:0] mef
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
    endfunction

    logic [7:0] pw [0:7];
    logic [7:0] m01_d, m5b_d, mef_d;
    logic [7:0] m01_q, m5b_q, mef_q;
    logic       out_valid_q;

    always_comb begin
        pw[0] = x;
        for (int unsigned k = 0; k < 7; k++) begin
            pw[k+1] = xtime(pw[k]);
        end
    end

    assign y = pw[1];

    // Constant products are XORs of the powers at the constant's set bits
    always_comb begin
        m01_d = pw[0];
        m5b_d = pw[6] ^ pw[4] ^ pw[3] ^ pw[1] ^ pw[0];
        mef_d = pw[7] ^ pw[6] ^ pw[5] ^ pw[3] ^ pw[2] ^ pw[1] ^ pw[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            m01_q       <= '0;
            m5b_q       <= '0;
            mef_q       <= '0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                m01_q <= m01_d;
                m5b_q <= m5b_d;
                mef_q <= mef_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign m01       = m01_q;
    assign m5b       = m5b_q;
    assign mef       = mef_q;

endmodule

// File: tb/tb_twofish_xtime.sv
// Directed bench for twofish_xtime: xtime sweep, product vectors, hold,
// asynchronous reset and linearity over GF(2^8) mod 0x169.
module tb_twofish_xtime;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst;
    logic [7:0] x;
    logic       in_valid;
    logic [7:0] y;
    logic       out_valid;
    logic [7:0] m01, m5b, mef;

    int n_tests = 0;
    int n_fail  = 0;

    twofish_xtime #(.POLY(8'h69)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .in_valid  (in_valid),
        .y         (y),
        .out_valid (out_valid),
        .m01       (m01),
        .m5b       (m5b),
        .mef       (mef)
    );

    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    typedef struct {
        logic [7:0] xin;
        logic [7:0] yexp;
    } ycase_t;

    typedef struct {
        logic [7:0] xin;
        logic [7:0] e01;
        logic [7:0] e5b;
        logic [7:0] eef;
    } pcase_t;

    ycase_t ytab [6];
    pcase_t ptab [3];

    function automatic logic [7:0] ref_xt(input logic [7:0] a);
        ref_xt = a[7] ? (8'(a << 1) ^ 8'h69) : 8'(a << 1);
    endfunction

    // Generic shift-and-add multiply used as the reference for products
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc, t;
        acc = '0;
        t   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ t;
            t = ref_xt(t);
        end
        gf_mul = acc;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [7:0] xv, input logic v);
        @(negedge clk);
        x = xv;
        in_valid = v;
        edge_sample();
    endtask

    task automatic capture(input logic [7:0] xv, output logic [7:0] o5b, output logic [7:0] oef);
        apply(xv, 1'b1);
        o5b = m5b;
        oef = mef;
    endtask

    logic [7:0] a, b, a5, aE, b5, bE, c5, cE, ya, yb;

    initial begin
        ytab[0] = '{8'h01, 8'h02};
        ytab[1] = '{8'h55, 8'hAA};
        ytab[2] = '{8'h80, 8'h69};
        ytab[3] = '{8'hAA, 8'h3D};
        ytab[4] = '{8'hFF, 8'h97};
        ytab[5] = '{8'h00, 8'h00};
        ptab[0] = '{8'h01, 8'h01, 8'h5B, 8'hEF};
        ptab[1] = '{8'h02, 8'h02, 8'hB6, 8'hB7};
        ptab[2] = '{8'h80, 8'h80, 8'hA0, 8'hE0};

        rst = 1'b1;
        x = '0;
        in_valid = 1'b0;
        #2;
        check("reset_out_valid", {7'b0, out_valid}, 8'h00);
        check("reset_m01", m01, 8'h00);
        check("reset_m5b", m5b, 8'h00);
        check("reset_mef", mef, 8'h00);

        // Combinational sweep with clock idle and reset held
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            #5;
            check($sformatf("y_sweep_%02h", i), y, ref_xt(8'(i)));
        end
        foreach (ytab[i]) begin
            x = ytab[i].xin;
            #5;
            check($sformatf("y_spot_%02h", ytab[i].xin), y, ytab[i].yexp);
        end

        clk_run = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        foreach (ptab[i]) begin
            apply(ptab[i].xin, 1'b1);
            check($sformatf("ov_%02h", ptab[i].xin), {7'b0, out_valid}, 8'h01);
            check($sformatf("m01_%02h", ptab[i].xin), m01, ptab[i].e01);
            check($sformatf("m5b_%02h", ptab[i].xin), m5b, ptab[i].e5b);
            check($sformatf("mef_%02h", ptab[i].xin), mef, ptab[i].eef);
            check($sformatf("m5b_model_%02h", ptab[i].xin), m5b, gf_mul(ptab[i].xin, 8'h5B));
        end

        apply(8'h02, 1'b1);
        check("hold_cap_m5b", m5b, 8'hB6);
        for (int i = 0; i < 3; i++) begin
            apply(8'hFF, 1'b0);
            check($sformatf("hold_m5b_%0d", i), m5b, 8'hB6);
            check($sformatf("hold_mef_%0d", i), mef, 8'hB7);
            check($sformatf("hold_ov_%0d", i), {7'b0, out_valid}, 8'h00);
            check($sformatf("hold_y_%0d", i), y, 8'h97);
        end

        apply(8'h01, 1'b1);
        check("prerst_ov", {7'b0, out_valid}, 8'h01);
        #2;
        rst = 1'b1;
        x = 8'h55;
        #1;
        check("arst_ov", {7'b0, out_valid}, 8'h00);
        check("arst_m01", m01, 8'h00);
        check("arst_m5b", m5b, 8'h00);
        check("arst_mef", mef, 8'h00);
        check("arst_y", y, 8'hAA);
        edge_sample();
        check("rst_held_ov", {7'b0, out_valid}, 8'h00);
        check("rst_held_m5b", m5b, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        apply(8'h01, 1'b1);
        check("post_rst_m5b", m5b, 8'h5B);
        check("post_rst_ov", {7'b0, out_valid}, 8'h01);

        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            capture(a, a5, aE);
            ya = y;
            capture(b, b5, bE);
            yb = y;
            capture(a ^ b, c5, cE);
            check($sformatf("lin_y_%0d", i), y, ya ^ yb);
            check($sformatf("lin_m5b_%0d", i), c5, a5 ^ b5);
            check($sformatf("lin_mef_%0d", i), cE, aE ^ bE);
            check($sformatf("lin_mef_model_%0d", i), cE, gf_mul(a ^ b, 8'hEF));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
